jump_unit_ras: RTL and testbench

- Parametrised next-generation jump/branch resolution unit for the multicycle MIPS datapath.
- Accepts one control-transfer request per handshake and resolves J, JAL, JR, JALR, BEQ and BNE into a registered next PC.
- Produces link-register write data and a taken flag.
- Keeps a return-address stack (RAS) that predicts JR $ra targets and flags mispredictions for the performance counters.

---
 rtl/jump_unit_ras_if.sv | 47 ++++
 rtl/jump_unit_ras.sv | 138 +++++++++++++
 tb/tb_jump_unit_ras.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/jump_unit_ras_if.sv
// Request/response bundle for the jump resolution unit.
// master = requester side, slave = the unit itself.
interface jump_unit_ras_if #(
    parameter int PC_W      = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    logic             req_valid;
    logic             req_ready;
    logic [2:0]       op;
    logic [PC_W-1:0]  pc;
    logic [25:0]      addr;
    logic [15:0]      imm;
    logic [PC_W-1:0]  reg_addr;
    logic [4:0]       rs_idx;
    logic [4:0]       rd_idx;
    logic [31:0]      src_a;
    logic [31:0]      src_b;
    logic             resp_valid;
    logic             resp_ready;
    logic [PC_W-1:0]  pc_out;
    logic             taken;
    logic             link_we;
    logic [4:0]       link_idx;
    logic [PC_W-1:0]  link_data;
    logic             ras_pred;
    logic             ras_hit;
    logic             illegal;
    logic [CNT_W-1:0] ras_count;

    modport master (
        output req_valid, op, pc, addr, imm, reg_addr,
        output rs_idx, rd_idx, src_a, src_b, resp_ready,
        input  req_ready, resp_valid, pc_out, taken,
        input  link_we, link_idx, link_data,
        input  ras_pred, ras_hit, illegal, ras_count
    );

    modport slave (
        input  req_valid, op, pc, addr, imm, reg_addr,
        input  rs_idx, rd_idx, src_a, src_b, resp_ready,
        output req_ready, resp_valid, pc_out, taken,
        output link_we, link_idx, link_data,
        output ras_pred, ras_hit, illegal, ras_count
    );
endinterface

// File: rtl/jump_unit_ras.sv
// Jump/branch resolution with registered next PC and
// a circular return-address stack for JR $ra prediction.
module jump_unit_ras #(
    parameter int PC_W      = 32,
    parameter int RAS_DEPTH = 4,
    parameter int LINK_REG  = 31
) (
    input logic            clk,
    input logic            rst_n,
    jump_unit_ras_if.slave bus
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [4:0] LINK_IDX = 5'(LINK_REG);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

    typedef enum logic {IDLE, RESP} state_t;

    typedef struct packed {
        logic [PC_W-1:0] pc_out;
        logic            taken;
        logic            link_we;
        logic [4:0]      link_idx;
        logic [PC_W-1:0] link_data;
        logic            ras_pred;
        logic            ras_hit;
        logic            illegal;
    } result_t;

    state_t           state_q, state_d;
    result_t          res_q, res_d;
    logic             armed_q;
    logic [PC_W-1:0]  ras_q [RAS_DEPTH];
    logic [PTR_W-1:0] top_q, top_m1;
    logic [CNT_W-1:0] cnt_q;

    logic            accept, push, pop, pop_ok, eq;
    logic            op_j, op_jal, op_jr, op_jalr, op_beq, op_bne;
    logic [PC_W-1:0] pc1, j_tgt, br_tgt;

    assign op_j    = bus.op == 3'b000;
    assign op_jal  = bus.op == 3'b001;
    assign op_jr   = bus.op == 3'b010;
    assign op_jalr = bus.op == 3'b011;
    assign op_beq  = bus.op == 3'b100;
    assign op_bne  = bus.op == 3'b101;

    assign pc1    = bus.pc + PC_W'(1);
    assign j_tgt  = {bus.pc[PC_W-1:26], bus.addr};
    assign br_tgt = pc1 + {{(PC_W-16){bus.imm[15]}}, bus.imm};
    assign eq     = bus.src_a == bus.src_b;
    assign top_m1 = top_q - PTR_W'(1);

    // ready stays low until the first edge after reset release
    assign bus.req_ready  = armed_q && (state_q == IDLE);
    assign bus.resp_valid = state_q == RESP;
    assign accept = bus.req_valid && bus.req_ready;

    assign pop_ok = op_jr && (bus.rs_idx == LINK_IDX) && (cnt_q != '0);
    assign push   = accept && (op_jal || op_jalr);
    assign pop    = accept && pop_ok;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RESP;
            RESP:    if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        res_d = '0;
        res_d.pc_out = pc1;
        unique case (1'b1)
            op_j, op_jal: begin
                res_d.pc_out = j_tgt;
                res_d.taken  = 1'b1;
            end
            op_jr, op_jalr: begin
                res_d.pc_out = bus.reg_addr;
                res_d.taken  = 1'b1;
            end
            op_beq: begin
                res_d.taken = eq;
                if (eq) res_d.pc_out = br_tgt;
            end
            op_bne: begin
                res_d.taken = !eq;
                if (!eq) res_d.pc_out = br_tgt;
            end
            default: res_d.illegal = 1'b1;
        endcase
        if (op_jal || op_jalr) begin
            res_d.link_we   = 1'b1;
            res_d.link_idx  = op_jal ? LINK_IDX : bus.rd_idx;
            res_d.link_data = pc1;
        end
        if (pop_ok) begin
            res_d.ras_pred = 1'b1;
            res_d.ras_hit  = ras_q[top_m1] == bus.reg_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            armed_q <= 1'b0;
            res_q   <= '0;
            top_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
        end else begin
            state_q <= state_d;
            armed_q <= 1'b1;
            if (accept) res_q <= res_d;
            // when full, top has wrapped onto the oldest slot
            if (push) begin
                ras_q[top_q] <= pc1;
                top_q <= top_q + PTR_W'(1);
                if (cnt_q != FULL) cnt_q <= cnt_q + CNT_W'(1);
            end else if (pop) begin
                top_q <= top_m1;
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign bus.pc_out    = res_q.pc_out;
    assign bus.taken     = res_q.taken;
    assign bus.link_we   = res_q.link_we;
    assign bus.link_idx  = res_q.link_idx;
    assign bus.link_data = res_q.link_data;
    assign bus.ras_pred  = res_q.ras_pred;
    assign bus.ras_hit   = res_q.ras_hit;
    assign bus.illegal   = res_q.illegal;
    assign bus.ras_count = cnt_q;
endmodule

// File: tb/tb_jump_unit_ras.sv
// Bench for jump_unit_ras: directed cases plus random traffic
// checked against a queue-based return-stack model.
module tb_jump_unit_ras;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int fails = 0;
    logic [31:0] ras [$];

    always #5 clk = ~clk;

    jump_unit_ras_if #(.PC_W(32), .RAS_DEPTH(DEPTH)) bus ();

    jump_unit_ras #(
        .PC_W(32), .RAS_DEPTH(DEPTH), .LINK_REG(31)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_dut();
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(bus.resp_valid), 0);
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_count", 32'(bus.ras_count), 0);
        chk("rst_pc", bus.pc_out, 0);
        chk("rst_taken", 32'(bus.taken), 0);
        chk("rst_lwe", 32'(bus.link_we), 0);
        chk("rst_ldata", bus.link_data, 0);
        chk("rst_ill", 32'(bus.illegal), 0);
        chk("rst_pred", 32'(bus.ras_pred), 0);
        ras.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", 32'(bus.req_ready), 1);
        chk("rel_valid", 32'(bus.resp_valid), 0);
    endtask

    task automatic send(input logic [2:0] op, input logic [31:0] pc,
                        input logic [25:0] addr, input logic [15:0] imm,
                        input logic [31:0] ra, input logic [4:0] rs,
                        input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input int hold,
                        input bit finish);
        logic [31:0] pc1, e_pc, e_ld, v;
        logic e_tk, e_we, e_pred, e_hit, e_ill;
        logic [4:0] e_idx;
        int n;
        pc1 = pc + 32'd1;
        e_pc = pc1; e_tk = 0; e_we = 0; e_idx = 0; e_ld = 0;
        e_pred = 0; e_hit = 0; e_ill = 0;
        case (op)
            3'd0, 3'd1: begin e_pc = {pc[31:26], addr}; e_tk = 1; end
            3'd2, 3'd3: begin e_pc = ra; e_tk = 1; end
            3'd4: e_tk = (a == b);
            3'd5: e_tk = (a != b);
            default: e_ill = 1;
        endcase
        if ((op == 3'd4 || op == 3'd5) && e_tk)
            e_pc = pc1 + {{16{imm[15]}}, imm};
        if (op == 3'd1 || op == 3'd3) begin
            e_we = 1;
            e_idx = (op == 3'd1) ? 5'd31 : rd;
            e_ld = pc1;
            ras.push_back(pc1);
            if (ras.size() > DEPTH) void'(ras.pop_front());
        end
        if (op == 3'd2 && rs == 5'd31 && ras.size() > 0) begin
            e_pred = 1;
            v = ras.pop_back();
            e_hit = (v == ra);
        end
        n = 0;
        while (!bus.req_ready && n < 10) begin @(negedge clk); n++; end
        chk("req_ready", 32'(bus.req_ready), 1);
        bus.op = op; bus.pc = pc; bus.addr = addr; bus.imm = imm;
        bus.reg_addr = ra; bus.rs_idx = rs; bus.rd_idx = rd;
        bus.src_a = a; bus.src_b = b;
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.op = 3'($urandom); bus.pc = $urandom; bus.reg_addr = $urandom;
        bus.rs_idx = 5'($urandom); bus.src_a = $urandom;
        chk("resp_valid", 32'(bus.resp_valid), 1);
        chk("busy_ready", 32'(bus.req_ready), 0);
        chk("pc_out", bus.pc_out, e_pc);
        chk("taken", 32'(bus.taken), 32'(e_tk));
        chk("link_we", 32'(bus.link_we), 32'(e_we));
        chk("link_idx", 32'(bus.link_idx), 32'(e_idx));
        chk("link_data", bus.link_data, e_ld);
        chk("ras_pred", 32'(bus.ras_pred), 32'(e_pred));
        chk("ras_hit", 32'(bus.ras_hit), 32'(e_hit));
        chk("illegal", 32'(bus.illegal), 32'(e_ill));
        chk("ras_count", 32'(bus.ras_count), 32'(ras.size()));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", 32'(bus.resp_valid), 1);
            chk("hold_ready", 32'(bus.req_ready), 0);
            chk("hold_pc", bus.pc_out, e_pc);
            chk("hold_count", 32'(bus.ras_count), 32'(ras.size()));
        end
        if (finish) begin
            bus.req_valid = 1'b0;
            bus.resp_ready = 1'b1;
            @(negedge clk);
            bus.resp_ready = 1'b0;
            chk("done_valid", 32'(bus.resp_valid), 0);
            chk("done_ready", 32'(bus.req_ready), 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] op;
        logic [4:0] rs;
        logic [31:0] ra;
        int r;
        bus.req_valid = 0; bus.resp_ready = 0; bus.op = 0; bus.pc = 0;
        bus.addr = 0; bus.imm = 0; bus.reg_addr = 0; bus.rs_idx = 0;
        bus.rd_idx = 0; bus.src_a = 0; bus.src_b = 0;
        reset_dut();
        send(3'd0, 32'h00400010, 26'h0000123, 0, 0, 0, 0, 0, 0, 3, 1);
        send(3'd4, 32'h100, 0, 16'hFFFE, 0, 0, 0, 5, 5, 0, 1);
        send(3'd5, 32'h100, 0, 16'hFFFE, 0, 0, 0, 5, 5, 0, 1);
        send(3'd1, 32'h200, 26'h40, 0, 0, 0, 0, 0, 0, 1, 1);
        send(3'd2, 32'h500, 0, 0, 32'h201, 31, 0, 0, 0, 0, 1);
        send(3'd1, 32'h200, 26'h40, 0, 0, 0, 0, 0, 0, 0, 1);
        send(3'd2, 32'h500, 0, 0, 32'h300, 31, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 5; i++)
            send(3'd1, 32'(i * 16), 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 5; i >= 1; i--)
            send(3'd2, 32'h900, 0, 0, 32'(i * 16 + 1), 31, 0, 0, 0, 0, 1);
        send(3'd3, 32'hFFFFFFFF, 0, 0, 32'h1234, 31, 7, 0, 0, 0, 1);
        send(3'd6, 32'h700, 0, 0, 0, 31, 0, 0, 0, 1, 1);
        send(3'd2, 32'h800, 0, 0, 32'h0, 31, 0, 0, 0, 0, 1);
        send(3'd1, 32'h1000, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        send(3'd1, 32'h2000, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        send(3'd1, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        reset_dut();
        send(3'd2, 32'h800, 0, 0, 32'h3001, 31, 0, 0, 0, 0, 1);
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 9);
            op = (r < 3) ? 3'd1 : (r < 6) ? 3'd2 : 3'($urandom_range(0, 7));
            rs = ($urandom_range(0, 3) != 0) ? 5'd31 : 5'($urandom);
            ra = $urandom;
            if (op == 3'd2 && ras.size() > 0 && $urandom_range(0, 1) == 1)
                ra = ras[ras.size() - 1];
            send(op, $urandom, 26'($urandom), 16'($urandom), ra, rs,
                 5'($urandom), 32'($urandom_range(0, 3)),
                 32'($urandom_range(0, 3)), $urandom_range(0, 2), 1);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
